// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 6502 netlist bus sequencer.
package cpu_bus_pkg;
    localparam int CNT_W  = 8;
    localparam int RCNT_W = 8;

    localparam logic [7:0]  DBI_RST  = 8'h00;
    localparam logic [15:0] ADDR_RST = 16'h0000;

    typedef enum logic [1:0] {
        S_PH1,
        S_PH2,
        S_WAIT,
        S_HOLD
    } state_e;
endpackage

// File: rtl/phi_timer.sv
// Phase counter for the phi generator: clear, saturate at HALF-1,
// terminal flag and bus-settle match flag.
module phi_timer
    import cpu_bus_pkg::*;
#(
    parameter int HALF   = 16,
    parameter int SETTLE = 12
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o,
    output logic             settle_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_o    = cnt_q;
    assign term_o   = (cnt_q == CNT_W'(HALF - 1));
    assign settle_o = (cnt_q == CNT_W'(SETTLE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !term_o)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cpu_6502_bus_ctrl.sv
// Bus sequencer between the transistor-level 6502 core and memory:
// phi generation, core reset hold, req/ack transaction, phi2 stretch.
module cpu_6502_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int HALF    = 16,
    parameter int SETTLE  = 12,
    parameter int RES_CYC = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        en,
    output logic        cpu_phi,
    output logic        cpu_res,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dbo,
    output logic [7:0]  cpu_dbi,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        cyc_stb
);
    state_e            state_q, state_d;
    logic              phi_q, phi_d;
    logic              cres_q, cres_d;
    logic [7:0]        dbi_q, dbi_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              stb_q, stb_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    logic             clr, inc, term, settle;
    logic [CNT_W-1:0] cnt;

    phi_timer #(
        .HALF   (HALF),
        .SETTLE (SETTLE)
    ) u_timer (
        .clk      (clk),
        .res      (res),
        .clr_i    (clr),
        .inc_i    (inc),
        .cnt_o    (cnt),
        .term_o   (term),
        .settle_o (settle)
    );

    always_comb begin
        state_d = state_q;
        phi_d   = phi_q;
        dbi_d   = dbi_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rcnt_d  = rcnt_q;
        stb_d   = 1'b0;
        clr     = 1'b0;
        inc     = 1'b1;

        unique case (state_q)
            S_PH1: begin
                // idle boundary: count held at 0 until en returns
                inc = (cnt != '0) || en;
                if (term) begin
                    state_d = S_PH2;
                    phi_d   = 1'b1;
                    clr     = 1'b1;
                end
            end
            S_PH2: begin
                if (settle) begin
                    addr_d  = cpu_ab;
                    we_d    = !cpu_rw;
                    wdata_d = cpu_dbo;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (req_q && mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q)
                        dbi_d = mem_rdata;
                    // a late ack past HALF-1 ends phi2 on the ack edge
                    state_d = term ? S_PH1 : S_HOLD;
                end
            end
            S_HOLD: begin
                if (term)
                    state_d = S_PH1;
            end
        endcase

        if (state_q != S_PH1 && state_d == S_PH1) begin
            phi_d = 1'b0;
            stb_d = 1'b1;
            clr   = 1'b1;
            if (rcnt_q != RCNT_W'(RES_CYC))
                rcnt_d = rcnt_q + RCNT_W'(1);
        end

        cres_d = cres_q || (rcnt_d == RCNT_W'(RES_CYC));
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_PH1;
            phi_q   <= 1'b0;
            cres_q  <= 1'b0;
            dbi_q   <= DBI_RST;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_RST;
            wdata_q <= 8'h00;
            stb_q   <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            phi_q   <= phi_d;
            cres_q  <= cres_d;
            dbi_q   <= dbi_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            stb_q   <= stb_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign cpu_phi   = phi_q;
    assign cpu_res   = cres_q;
    assign cpu_dbi   = dbi_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cyc_stb   = stb_q;
endmodule

// File: tb/tb_cpu_6502_bus_ctrl.sv
// Directed bench for cpu_6502_bus_ctrl with HALF=8, SETTLE=4, RES_CYC=2
// and a latency-programmable memory model.
module tb_cpu_6502_bus_ctrl;
    logic        clk = 1'b0;
    logic        res;
    logic        en;
    logic        cpu_phi;
    logic        cpu_res;
    logic [15:0] cpu_ab;
    logic        cpu_rw;
    logic [7:0]  cpu_dbo;
    logic [7:0]  cpu_dbi;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack   = 1'b0;
    logic        cyc_stb;

    int   lat       = 0;
    int   wcnt      = 0;
    logic force_ack = 1'b0;
    int   n_chk     = 0;
    int   n_fail    = 0;

    typedef struct {
        int          lo;
        int          hi;
        int          req_off;
        int          req_len;
        int          stbs;
        int          hold_bad;
        logic [15:0] a;
        logic        we;
        logic [7:0]  wd;
        logic [7:0]  dbi_rise;
        logic [7:0]  dbi_ack;
        logic [7:0]  dbi_fall;
        logic        res_stb;
    } cyc_t;

    cpu_6502_bus_ctrl #(
        .HALF    (8),
        .SETTLE  (4),
        .RES_CYC (2)
    ) dut (
        .clk       (clk),
        .res       (res),
        .en        (en),
        .cpu_phi   (cpu_phi),
        .cpu_res   (cpu_res),
        .cpu_ab    (cpu_ab),
        .cpu_rw    (cpu_rw),
        .cpu_dbo   (cpu_dbo),
        .cpu_dbi   (cpu_dbi),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .cyc_stb   (cyc_stb)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [15:0] a);
        case (a)
            16'hFFFC: rd = 8'h4C;
            16'h1000: rd = 8'h11;
            16'h1001: rd = 8'h22;
            default:  rd = 8'hEE;
        endcase
    endfunction

    // memory: ack 'lat' cycles after the first req cycle
    always begin
        @(posedge clk);
        #2;
        if (!mem_req) begin
            wcnt    = 0;
            mem_ack = force_ack;
        end else begin
            mem_ack = (wcnt == lat) || force_ack;
            wcnt    = wcnt + 1;
        end
        mem_rdata = rd(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_cycle(input logic [15:0] ab, input logic rw,
                             input logic [7:0] dbo, input int l,
                             input logic drop_en, output cyc_t r);
        int  n;
        logic ack_seen;
        cpu_ab    = ab;
        cpu_rw    = rw;
        cpu_dbo   = dbo;
        lat       = l;
        r.lo      = 1;
        r.hi      = 0;
        r.req_off = -1;
        r.req_len = 0;
        r.stbs    = 0;
        r.hold_bad = 0;
        r.a       = '0;
        r.we      = 1'b0;
        r.wd      = '0;
        r.dbi_ack = '0;
        ack_seen  = 1'b0;
        n = 0;
        while (!cpu_phi && n < 200) begin
            @(negedge clk);
            n++;
            if (!cpu_phi)
                r.lo++;
        end
        chk("phi_rise_in_time", 32'(n < 200), 1);
        r.dbi_rise = cpu_dbi;
        while (cpu_phi && r.hi < 100) begin
            r.hi++;
            if (drop_en)
                en = 1'b0;
            if (mem_req) begin
                if (r.req_off < 0) begin
                    r.req_off = r.hi - 1;
                    r.a  = mem_addr;
                    r.we = mem_we;
                    r.wd = mem_wdata;
                    cpu_ab  = ~ab;
                    cpu_rw  = ~rw;
                    cpu_dbo = ~dbo;
                end else if (mem_addr != r.a || mem_we != r.we ||
                             mem_wdata != r.wd) begin
                    r.hold_bad++;
                end
                r.req_len++;
            end else if (r.req_len > 0 && !ack_seen) begin
                ack_seen  = 1'b1;
                r.dbi_ack = cpu_dbi;
            end
            r.stbs += int'(cyc_stb);
            @(negedge clk);
        end
        chk("phi_fall_in_time", 32'(r.hi < 100), 1);
        if (!ack_seen)
            r.dbi_ack = cpu_dbi;
        r.stbs    += int'(cyc_stb);
        r.res_stb  = cpu_res;
        r.dbi_fall = cpu_dbi;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc_t c;
        int   n;
        int   bad;
        res     = 1'b1;
        en      = 1'b0;
        cpu_ab  = 16'hFFFC;
        cpu_rw  = 1'b1;
        cpu_dbo = 8'h00;
        #2 res = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_phi",   32'(cpu_phi),   0);
        chk("rst_res",   32'(cpu_res),   0);
        chk("rst_dbi",   32'(cpu_dbi),   0);
        chk("rst_req",   32'(mem_req),   0);
        chk("rst_we",    32'(mem_we),    0);
        chk("rst_addr",  32'(mem_addr),  0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_stb",   32'(cyc_stb),   0);

        res = 1'b1;
        en  = 1'b1;
        bus_cycle(16'hFFFC, 1'b1, 8'h00, 0, 1'b0, c);
        chk("c1_hi",      32'(c.hi),       8);
        chk("c1_req_off", 32'(c.req_off),  4);
        chk("c1_req_len", 32'(c.req_len),  1);
        chk("c1_addr",    32'(c.a),        32'hFFFC);
        chk("c1_we",      32'(c.we),       0);
        chk("c1_dbi_ack", 32'(c.dbi_ack),  32'h4C);
        chk("c1_dbi_fall",32'(c.dbi_fall), 32'h4C);
        chk("c1_stbs",    32'(c.stbs),     1);
        chk("c1_res",     32'(c.res_stb),  0);

        bus_cycle(16'h0200, 1'b0, 8'hA5, 10, 1'b0, c);
        chk("c2_lo",       32'(c.lo),       8);
        chk("c2_hi",       32'(c.hi),       15);
        chk("c2_req_off",  32'(c.req_off),  4);
        chk("c2_req_len",  32'(c.req_len),  11);
        chk("c2_addr",     32'(c.a),        32'h0200);
        chk("c2_we",       32'(c.we),       1);
        chk("c2_wdata",    32'(c.wd),       32'hA5);
        chk("c2_hold",     32'(c.hold_bad), 0);
        chk("c2_dbi_fall", 32'(c.dbi_fall), 32'h4C);
        chk("c2_stbs",     32'(c.stbs),     1);
        chk("c2_res",      32'(c.res_stb),  1);

        bus_cycle(16'h1000, 1'b1, 8'h00, 3, 1'b0, c);
        chk("c3_hi",       32'(c.hi),       8);
        chk("c3_req_len",  32'(c.req_len),  4);
        chk("c3_dbi_ack",  32'(c.dbi_ack),  32'h11);
        chk("c3_dbi_fall", 32'(c.dbi_fall), 32'h11);
        chk("c3_stbs",     32'(c.stbs),     1);

        bus_cycle(16'h1001, 1'b1, 8'h00, 3, 1'b1, c);
        chk("c4_lo",       32'(c.lo),       8);
        chk("c4_dbi_rise", 32'(c.dbi_rise), 32'h11);
        chk("c4_dbi_ack",  32'(c.dbi_ack),  32'h22);
        chk("c4_hi",       32'(c.hi),       8);
        chk("c4_stbs",     32'(c.stbs),     1);
        chk("c4_res",      32'(c.res_stb),  1);

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            bad += int'(cpu_phi) + int'(mem_req) + int'(cyc_stb);
        end
        chk("idle_activity", 32'(bad), 0);

        cpu_ab = 16'h0400;
        cpu_rw = 1'b1;
        lat    = 100;
        en     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_phi && n < 50);
        chk("restart_lo", 32'(n), 8);

        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("c5_req_seen", 32'(mem_req), 1);
        res = 1'b0;
        #1;
        chk("c5_phi",  32'(cpu_phi),  0);
        chk("c5_req",  32'(mem_req),  0);
        chk("c5_addr", 32'(mem_addr), 0);
        chk("c5_we",   32'(mem_we),   0);
        chk("c5_dbi",  32'(cpu_dbi),  0);
        chk("c5_res",  32'(cpu_res),  0);
        @(negedge clk);
        res       = 1'b1;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        chk("c5_late_ack_dbi", 32'(cpu_dbi), 0);
        chk("c5_late_ack_req", 32'(mem_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
